dma_burst_master: RTL and testbench

DMA_BURST_MASTER -- requirements
Module: dma_burst_master

---
 rtl/dma_burst_master.sv | 218 +++++++++++++++++++++
 tb/tb_dma_burst_master.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_burst_master.sv
// dma_burst_master: single-outstanding AXI4 burst master. It accepts one
// command at a time, validates it (beat alignment, length, 4 KB boundary),
// then runs either a write burst fed from the wr_* stream or a read burst
// delivered to the rd_* stream. Data beats pass straight through without
// buffering, so all backpressure is end to end.
// Optional feature: define DMA_PERF_CNT_EN to build the perf_cycles busy-cycle
// counter; without it perf_cycles is tied to zero.
module dma_burst_master #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 1024,
  parameter int MAX_BEATS = 8,
  parameter int LEN_W     = 5
) (
  input  logic                aclk,
  input  logic                aresetn,
  // command channel
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_dir,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  // write-beat source
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                wr_valid,
  output logic                wr_ready,
  // read-beat sink
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic                rd_last,
  // AXI4 write address
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  // AXI4 write data
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  // AXI4 write response
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  // AXI4 read address
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  // AXI4 read data
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  // status
  output logic                done,
  output logic                busy,
  output logic [1:0]          err,
  input  logic                err_clr,
  output logic [31:0]         perf_cycles
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA} state_t;

  state_t             r_state, w_next;
  logic [ADDR_W-1:0]  r_addr;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_beat;
  logic               r_done;
  logic [1:0]         r_err;

  logic               w_cmd_fire, w_misaligned, w_len_bad, w_cross, w_cmd_ok;
  logic [31:0]        w_burst_end;
  logic               w_w_fire, w_w_last, w_b_fire, w_r_fire, w_done_set;
  logic [1:0]         w_err_set;

  // Command validation: every accepted command is checked in IDLE; a bad one
  // only sets error bits and the FSM never leaves IDLE.
  assign w_cmd_fire   = cmd_valid && (r_state == IDLE);
  assign w_misaligned = |cmd_addr[OFF_W-1:0];
  assign w_len_bad    = (cmd_len == '0) || (32'(cmd_len) > 32'(MAX_BEATS));
  assign w_burst_end  = 32'(cmd_addr[11:0]) + 32'(cmd_len) * 32'(BYTES);
  assign w_cross      = w_burst_end > 32'd4096;
  assign w_cmd_ok     = w_cmd_fire && !w_misaligned && !w_len_bad && !w_cross;

  assign w_w_fire   = (r_state == WR_DATA) && wr_valid && m_axi_wready;
  assign w_w_last   = r_beat == (r_len - LEN_W'(1));
  assign w_b_fire   = (r_state == WR_RESP) && m_axi_bvalid;
  assign w_r_fire   = (r_state == RD_DATA) && m_axi_rvalid && rd_ready;
  assign w_done_set = w_b_fire || (w_r_fire && m_axi_rlast);

  assign w_err_set[0] = w_cmd_fire && w_misaligned;
  assign w_err_set[1] = (w_cmd_fire && (w_len_bad || w_cross)) ||
                        (w_b_fire && (m_axi_bresp != 2'b00)) ||
                        (w_r_fire && (m_axi_rresp != 2'b00));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode and handshake outputs.
  // NOTE: every signal gets a default before the case, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    w_next        = r_state;
    cmd_ready     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    wr_ready      = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_rready  = 1'b0;
    rd_valid      = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (w_cmd_ok) w_next = cmd_dir ? WR_ADDR : RD_ADDR;
      end
      WR_ADDR: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) w_next = WR_DATA;
      end
      WR_DATA: begin
        m_axi_wvalid = wr_valid;
        wr_ready     = m_axi_wready;
        if (w_w_fire && w_w_last) w_next = WR_RESP;
      end
      WR_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) w_next = IDLE;
      end
      RD_ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) w_next = RD_DATA;
      end
      RD_DATA: begin
        rd_valid     = m_axi_rvalid;
        m_axi_rready = rd_ready;
        if (w_r_fire && m_axi_rlast) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Command latch and write beat counter.
  // NOTE: address and length are reset too, so a freshly reset block drives
  // known values on the AXI address buses instead of X.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_addr <= '0;
      r_len  <= '0;
      r_beat <= '0;
    end else if (w_cmd_ok) begin
      r_addr <= cmd_addr;
      r_len  <= cmd_len;
      r_beat <= '0;
    end else if (w_w_fire) begin
      r_beat <= r_beat + LEN_W'(1);
    end
  end

  // Completion pulse and sticky error bits; a new error beats a same-cycle clear.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_done <= 1'b0;
      r_err  <= 2'b00;
    end else begin
      r_done <= w_done_set;
      r_err  <= (err_clr ? 2'b00 : r_err) | w_err_set;
    end
  end

  assign m_axi_awaddr  = r_addr;
  assign m_axi_araddr  = r_addr;
  assign m_axi_awlen   = 8'(r_len) - 8'd1;
  assign m_axi_arlen   = 8'(r_len) - 8'd1;
  assign m_axi_awsize  = 3'(OFF_W);
  assign m_axi_arsize  = 3'(OFF_W);
  assign m_axi_awburst = 2'b01;
  assign m_axi_arburst = 2'b01;
  assign m_axi_wdata   = wr_data;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = (r_state == WR_DATA) && w_w_last;
  assign rd_data       = m_axi_rdata;
  assign rd_last       = (r_state == RD_DATA) && m_axi_rlast;
  assign done          = r_done;
  assign err           = r_err;
  assign busy          = r_state != IDLE;

`ifdef DMA_PERF_CNT_EN
  logic [31:0] r_perf;

  // Busy-cycle counter: restarts on each accepted command, saturates.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                               r_perf <= '0;
    else if (w_cmd_fire)                        r_perf <= '0;
    else if (r_state != IDLE && r_perf != '1)   r_perf <= r_perf + 32'd1;
  end

  assign perf_cycles = r_perf;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_dma_burst_master.sv
// Directed self-checking bench for dma_burst_master with a cycle-stepped AXI
// slave model and scoreboard queues for address, write and read beats.
module tb_dma_burst_master;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 1024;
  localparam int MAX_BEATS = 8;
  localparam int LEN_W     = 5;

  logic                aclk, aresetn;
  logic                cmd_valid, cmd_ready, cmd_dir;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [LEN_W-1:0]    cmd_len;
  logic [DATA_W-1:0]   wr_data;
  logic                wr_valid, wr_ready;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_valid, rd_ready, rd_last;
  logic [ADDR_W-1:0]   m_axi_awaddr, m_axi_araddr;
  logic [7:0]          m_axi_awlen, m_axi_arlen;
  logic [2:0]          m_axi_awsize, m_axi_arsize;
  logic [1:0]          m_axi_awburst, m_axi_arburst;
  logic                m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
  logic [DATA_W-1:0]   m_axi_wdata, m_axi_rdata;
  logic [DATA_W/8-1:0] m_axi_wstrb;
  logic                m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0]          m_axi_bresp, m_axi_rresp;
  logic                m_axi_bvalid, m_axi_bready;
  logic                m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic                done, busy, err_clr;
  logic [1:0]          err;
  logic [31:0]         perf_cycles;

  dma_burst_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS), .LEN_W(LEN_W)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .done(done), .busy(busy), .err(err), .err_clr(err_clr), .perf_cycles(perf_cycles)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } beat_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
  } addr_t;

  beat_t src_q[$], exp_w[$], slv_r[$], exp_r[$];
  addr_t exp_aw[$], exp_ar[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int aw_valid_cnt = 0, ar_valid_cnt = 0, done_cnt = 0, w_hs_cnt = 0;
  int aw_wait = 0, aw_cnt = 0, b_hs_cyc = 0, done_cyc = 0;
  bit rd_toggle = 1'b0, ar_open = 1'b0;
  logic [1:0] b_resp_knob = 2'b00;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_data(input string tag, input logic [DATA_W-1:0] got,
                            input logic [DATA_W-1:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed(lo64)=%0h expected(lo64)=%0h", tag, got[63:0], exp[63:0]);
    end
  endtask

  function automatic beat_t mk(input int seed, input logic [1:0] resp, input logic last);
    beat_t b;
    logic [31:0] w;
    w = 32'(seed) * 32'h9E37_79B1 + 32'h0000_1234;
    b.data = {32{w}};
    b.resp = resp;
    b.last = last;
    return b;
  endfunction

  // Slave and source responses for the current cycle, driven just after the edge.
  task automatic drive();
    cmd_valid = 1'b0;
    err_clr   = 1'b0;
    if (m_axi_awvalid) begin
      m_axi_awready = (aw_cnt >= aw_wait);
      aw_cnt++;
    end else begin
      m_axi_awready = 1'b0;
      aw_cnt = 0;
    end
    m_axi_arready = m_axi_arvalid;
    m_axi_wready  = 1'b1;
    wr_valid      = src_q.size() > 0;
    wr_data       = wr_valid ? src_q[0].data : '0;
    m_axi_bvalid  = m_axi_bready;
    m_axi_bresp   = m_axi_bready ? b_resp_knob : 2'b00;
    m_axi_rvalid  = ar_open && (slv_r.size() > 0);
    m_axi_rdata   = m_axi_rvalid ? slv_r[0].data : '0;
    m_axi_rresp   = m_axi_rvalid ? slv_r[0].resp : 2'b00;
    m_axi_rlast   = m_axi_rvalid ? slv_r[0].last : 1'b0;
    rd_ready      = rd_toggle ? ~rd_ready : 1'b1;
  endtask

  // Observe what will handshake on the coming edge and score it.
  task automatic monitor();
    beat_t b;
    addr_t a;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (m_axi_awvalid) begin
      aw_valid_cnt++;
      if (exp_aw.size() == 0) check("aw_unexpected", 1, 0);
      else begin
        a = exp_aw[0];
        check("awaddr", m_axi_awaddr, a.addr);
        check("awlen", m_axi_awlen, a.len);
        check("awburst", m_axi_awburst, 2'b01);
        if (m_axi_awready) a = exp_aw.pop_front();
      end
    end
    if (m_axi_arvalid) begin
      ar_valid_cnt++;
      if (exp_ar.size() == 0) check("ar_unexpected", 1, 0);
      else begin
        a = exp_ar[0];
        check("araddr", m_axi_araddr, a.addr);
        check("arlen", m_axi_arlen, a.len);
        check("arburst", m_axi_arburst, 2'b01);
        if (m_axi_arready) begin
          a = exp_ar.pop_front();
          ar_open = 1'b1;
        end
      end
    end
    if (m_axi_wvalid && m_axi_wready) begin
      w_hs_cnt++;
      if (src_q.size() > 0) b = src_q.pop_front();
      if (exp_w.size() == 0) check("w_unexpected", 1, 0);
      else begin
        b = exp_w.pop_front();
        check_data("wdata", m_axi_wdata, b.data);
        check("wlast", m_axi_wlast, b.last);
      end
    end
    if (m_axi_bvalid && m_axi_bready) b_hs_cyc = cyc;
    if (m_axi_rvalid && m_axi_rready) begin
      if (m_axi_rlast) ar_open = 1'b0;
      if (slv_r.size() > 0) b = slv_r.pop_front();
    end
    if (rd_valid && rd_ready) begin
      if (exp_r.size() == 0) check("r_unexpected", 1, 0);
      else begin
        b = exp_r.pop_front();
        check_data("rd_data", rd_data, b.data);
        check("rd_last", rd_last, b.last);
      end
    end
  endtask

  task automatic cycle();
    @(posedge aclk);
    cyc++;
    #1;
    drive();
    @(negedge aclk);
    monitor();
  endtask

  task automatic send_cmd(input logic dir, input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_addr  = addr;
    cmd_len   = len;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int start;
    bit got;
    start = done_cnt;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (done_cnt != start) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, got, 1);
  endtask

  task automatic expect_reject(input string tag, input logic dir, input logic [ADDR_W-1:0] addr,
                               input logic [LEN_W-1:0] len, input logic [1:0] exp_err);
    send_cmd(dir, addr, len);
    cycle();
    check({tag, "_err"}, err, exp_err);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    cycle();
    err_clr = 1'b1;
    cycle();
    check({tag, "_err_clr"}, err, 2'b00);
  endtask

  initial begin
    int aw0, ar0, d0, w0;
    bit hit;
    cmd_valid = 0; cmd_dir = 0; cmd_addr = '0; cmd_len = '0; err_clr = 0;
    wr_data = '0; wr_valid = 0; rd_ready = 0;
    m_axi_awready = 0; m_axi_arready = 0; m_axi_wready = 0;
    m_axi_bvalid = 0; m_axi_bresp = 0;
    m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = 0; m_axi_rlast = 0;
    aresetn = 1'b1;
    #2 aresetn = 1'b0;

    // Reset state
    repeat (3) cycle();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_perf", perf_cycles, 0);
    check("rst_awvalid", m_axi_awvalid, 0);
    check("rst_arvalid", m_axi_arvalid, 0);
    check("rst_wvalid", m_axi_wvalid, 0);
    check("rst_bready", m_axi_bready, 0);
    check("rst_rready", m_axi_rready, 0);
    aresetn = 1'b1;
    cycle();
    check("idle_cmd_ready", cmd_ready, 1);

    // Write 0x1000 len 4, zero-wait slave
    for (int i = 0; i < 4; i++) begin
      src_q.push_back(mk(i, 2'b00, 1'b0));
      exp_w.push_back(mk(i, 2'b00, i == 3));
    end
    exp_aw.push_back('{32'h0000_1000, 8'd3});
    w0 = w_hs_cnt;
    send_cmd(1'b1, 32'h0000_1000, 5'd4);
    run_until_done("wr4", 40);
    check("wr4_done_latency", done_cyc - b_hs_cyc, 1);
    check("wr4_beats", w_hs_cnt - w0, 4);
    check("wr4_exp_w_left", exp_w.size(), 0);
    check("wr4_err", err, 0);
    cycle();
    check("wr4_done_pulse", done, 0);
    check("wr4_busy_after", busy, 0);

    // Read 0x2080 len 2 with rd_ready toggling
    rd_toggle = 1'b1;
    slv_r.push_back(mk(10, 2'b00, 1'b0));
    slv_r.push_back(mk(11, 2'b00, 1'b1));
    exp_r.push_back(mk(10, 2'b00, 1'b0));
    exp_r.push_back(mk(11, 2'b00, 1'b1));
    exp_ar.push_back('{32'h0000_2080, 8'd1});
    d0 = done_cnt;
    send_cmd(1'b0, 32'h0000_2080, 5'd2);
    run_until_done("rd2", 40);
    repeat (3) cycle();
    check("rd2_done_once", done_cnt - d0, 1);
    check("rd2_exp_r_left", exp_r.size(), 0);
    check("rd2_err", err, 0);
    rd_toggle = 1'b0;

    // Rejected commands: no AXI traffic, no done
    aw0 = aw_valid_cnt;
    ar0 = ar_valid_cnt;
    d0  = done_cnt;
    expect_reject("rej_misalign", 1'b1, 32'h0000_1004, 5'd1, 2'b01);
    expect_reject("rej_len0", 1'b0, 32'h0000_1000, 5'd0, 2'b10);
    expect_reject("rej_len9", 1'b1, 32'h0000_1000, 5'd9, 2'b10);
    expect_reject("rej_4k", 1'b1, 32'h0000_0F80, 5'd2, 2'b10);
    check("rej_no_aw", aw_valid_cnt - aw0, 0);
    check("rej_no_ar", ar_valid_cnt - ar0, 0);
    check("rej_no_done", done_cnt - d0, 0);

    // Read with SLVERR on beat 1 still completes and flags err[1]
    slv_r.push_back(mk(20, 2'b10, 1'b0));
    slv_r.push_back(mk(21, 2'b00, 1'b1));
    exp_r.push_back(mk(20, 2'b10, 1'b0));
    exp_r.push_back(mk(21, 2'b00, 1'b1));
    exp_ar.push_back('{32'h0000_4000, 8'd1});
    send_cmd(1'b0, 32'h0000_4000, 5'd2);
    run_until_done("rderr", 40);
    check("rderr_err", err, 2'b10);
    check("rderr_exp_r_left", exp_r.size(), 0);
    err_clr = 1'b1;
    cycle();
    check("rderr_clr", err, 2'b00);

    // len=1 write with awready delayed 3 cycles: 4 AW + 1 W + 1 B busy cycles
    aw_wait = 3;
    src_q.push_back(mk(30, 2'b00, 1'b0));
    exp_w.push_back(mk(30, 2'b00, 1'b1));
    exp_aw.push_back('{32'h0000_3000, 8'd0});
    aw0 = aw_valid_cnt;
    send_cmd(1'b1, 32'h0000_3000, 5'd1);
    run_until_done("wrslow", 40);
    check("wrslow_aw_hold", aw_valid_cnt - aw0, 4);
    repeat (2) cycle();
`ifdef DMA_PERF_CNT_EN
    check("perf_cycles", perf_cycles, 6);
`else
    check("perf_cycles", perf_cycles, 0);
`endif
    check("wrslow_err", err, 0);
    aw_wait = 0;

    // Reset asserted while beat 2 of a write burst is on the W channel
    for (int i = 0; i < 4; i++) begin
      src_q.push_back(mk(40 + i, 2'b00, 1'b0));
      exp_w.push_back(mk(40 + i, 2'b00, i == 3));
    end
    exp_aw.push_back('{32'h0000_1000, 8'd3});
    w0 = w_hs_cnt;
    send_cmd(1'b1, 32'h0000_1000, 5'd4);
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (w_hs_cnt - w0 >= 2) begin
        hit = 1'b1;
        break;
      end
    end
    check("mid_rst_reached_beat2", hit, 1);
    check("mid_rst_busy_before", busy, 1);
    aresetn = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_wvalid", m_axi_wvalid, 0);
    check("mid_rst_wr_ready", wr_ready, 0);
    check("mid_rst_awvalid", m_axi_awvalid, 0);
    check("mid_rst_bready", m_axi_bready, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_perf", perf_cycles, 0);
    src_q.delete();
    exp_w.delete();
    exp_aw.delete();
    cycle();
    aresetn = 1'b1;
    cycle();
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
